// File: rtl/sw_led_pkg.sv
// Shared definitions for the switch-to-LED controller: display mode encoding.
package sw_led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ONEHOT = 2'd0;
  localparam mode_t MODE_THERM  = 2'd1;
  localparam mode_t MODE_BLINK  = 2'd2;
  localparam mode_t MODE_OFF    = 2'd3;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer; emits the accepted code
// and a one-cycle strobe on the edge where that code changes.
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int N_SW       = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] stable,
  output logic            update
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [N_SW-1:0] sync1_r;
  logic [N_SW-1:0] sync2_r;
  logic [N_SW-1:0] cand_r;
  logic [N_SW-1:0] stable_r;
  logic [CW-1:0]   cnt_r;
  logic            update_r;

  // Synchronise the raw switches and accept a code only after it has held for DEB_CYCLES edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= {N_SW{1'b0}};
      sync2_r  <= {N_SW{1'b0}};
      cand_r   <= {N_SW{1'b0}};
      stable_r <= {N_SW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      update_r <= 1'b0;
    end else begin
      sync1_r  <= sw;
      sync2_r  <= sync1_r;
      update_r <= 1'b0;
      if (sync2_r != cand_r) begin
        cand_r <= sync2_r;
        cnt_r  <= {CW{1'b0}};
      end else if (cand_r != stable_r) begin
        if (cnt_r == CNT_LAST) begin
          stable_r <= cand_r;
          cnt_r    <= {CW{1'b0}};
          update_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + 1'b1;
        end
      end else begin
        // Candidate matches the accepted code again: nothing pending.
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign stable = stable_r;
  assign update = update_r;

endmodule

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: debounced switch code decoded onto 2^N_SW LEDs
// in one-hot, thermometer, blinking one-hot or off mode.
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int N_SW       = 3,
  parameter int DEB_CYCLES = 4,
  parameter int BLINK_DIV  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SW-1:0]      sw,
  input  mode_t                mode,
  output logic [(1<<N_SW)-1:0] led,
  output logic [N_SW-1:0]      code,
  output logic                 change
);

  localparam int LEDS = 1 << N_SW;
  localparam int DW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

  logic [N_SW-1:0] stable_s;
  logic            update_s;
  logic [LEDS-1:0] onehot_s;
  logic [LEDS-1:0] led_next_s;
  logic [DW-1:0]   div_r;
  logic            phase_r;
  logic [LEDS-1:0] led_r;
  logic            change_r;

  sw_debounce #(
    .N_SW      (N_SW),
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .stable(stable_s),
    .update(update_s)
  );

  assign onehot_s = {{(LEDS-1){1'b0}}, 1'b1} << stable_s;

  // Select the next LED pattern from the current code, mode and blink phase.
  always_comb begin
    led_next_s = {LEDS{1'b0}};
    case (mode)
      MODE_ONEHOT: led_next_s = onehot_s;
      MODE_THERM: begin
        for (int i = 0; i < LEDS; i++) begin
          led_next_s[i] = (N_SW'(i) <= stable_s);
        end
      end
      MODE_BLINK:  led_next_s = phase_r ? onehot_s : {LEDS{1'b0}};
      MODE_OFF:    led_next_s = {LEDS{1'b0}};
      default:     led_next_s = {LEDS{1'b0}};
    endcase
  end

  // Blink divider, LED register and change pulse; change lines up with the led update.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r    <= {DW{1'b0}};
      phase_r  <= 1'b0;
      led_r    <= {LEDS{1'b0}};
      change_r <= 1'b0;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r   <= {DW{1'b0}};
        phase_r <= ~phase_r;
      end else begin
        div_r <= div_r + 1'b1;
      end
      led_r    <= led_next_s;
      change_r <= update_s;
    end
  end

  assign led    = led_r;
  assign code   = stable_s;
  assign change = change_r;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Scoreboard bench for sw_led_ctrl: expectations are queued against absolute
// edge numbers when stimulus is driven and compared on the falling edge.
module tb_sw_led_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] sw;
  logic [1:0] mode;
  logic [7:0] led;
  logic [2:0] code;
  logic       change;

  sw_led_ctrl #(
    .N_SW      (3),
    .DEB_CYCLES(4),
    .BLINK_DIV (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .mode  (mode),
    .led   (led),
    .code  (code),
    .change(change)
  );

  localparam int SEL_LED    = 0;
  localparam int SEL_CODE   = 1;
  localparam int SEL_CHANGE = 2;
  // Last edge with rst high at the start of the run; the blink divider restarts there.
  localparam int REL_EDGE   = 2;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t ent;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  task automatic push_exp(input int cyc, input int sel, input logic [7:0] val);
    exp_t e;
    int   i;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic expect_span(input int from, input int to, input int sel, input logic [7:0] val);
    for (int c = from; c <= to; c++) push_exp(c, sel, val);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Blink phase held after edge e: toggles every 8 edges counted from the reset edge.
  function automatic bit phase_after(input int e);
    return (((e - REL_EDGE) / 8) % 2) == 1;
  endfunction

  // Compare every expectation due at the current edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      ent = sb.pop_front();
      case (ent.sel)
        SEL_LED:  check_eq("led", {24'd0, led}, {24'd0, ent.val});
        SEL_CODE: check_eq("code", {29'd0, code}, {24'd0, ent.val});
        default:  check_eq("change", {31'd0, change}, {24'd0, ent.val});
      endcase
    end
  end

  initial begin
    int e;
    rst  = 1'b1;
    sw   = 3'd0;
    mode = 2'd0;

    // Reset: outputs cleared while rst is high, led[0] on the first edge after release.
    expect_span(1, 2, SEL_LED, 8'h00);
    expect_span(1, 2, SEL_CODE, 8'h00);
    expect_span(1, 2, SEL_CHANGE, 8'h00);
    step(2);
    rst = 1'b0;
    e = edge_cnt;
    expect_span(e + 1, e + 2, SEL_LED, 8'h01);
    expect_span(e + 1, e + 2, SEL_CODE, 8'h00);
    expect_span(e + 1, e + 2, SEL_CHANGE, 8'h00);
    step(2);

    // Three-cycle glitch to 3'b011 never gets accepted.
    e = edge_cnt;
    sw = 3'b011;
    expect_span(e + 1, e + 14, SEL_LED, 8'h01);
    expect_span(e + 1, e + 14, SEL_CODE, 8'h00);
    expect_span(e + 1, e + 14, SEL_CHANGE, 8'h00);
    step(3);
    sw = 3'b000;
    step(12);

    // Accept 3'b101: code at edge 7, led and change at edge 8.
    e = edge_cnt;
    sw = 3'b101;
    expect_span(e + 1, e + 6, SEL_CODE, 8'h00);
    expect_span(e + 7, e + 9, SEL_CODE, 8'h05);
    expect_span(e + 1, e + 7, SEL_LED, 8'h01);
    expect_span(e + 8, e + 9, SEL_LED, 8'h20);
    expect_span(e + 1, e + 7, SEL_CHANGE, 8'h00);
    push_exp(e + 8, SEL_CHANGE, 8'h01);
    expect_span(e + 9, e + 10, SEL_CHANGE, 8'h00);
    step(11);

    // Thermometer then off, each one edge after the mode is sampled.
    e = edge_cnt;
    mode = 2'd1;
    expect_span(e + 1, e + 2, SEL_LED, 8'h3F);
    step(2);
    e = edge_cnt;
    mode = 2'd3;
    expect_span(e + 1, e + 3, SEL_LED, 8'h00);
    step(3);

    // Move to code 2 while off, then blink.
    e = edge_cnt;
    sw = 3'b010;
    expect_span(e + 1, e + 8, SEL_LED, 8'h00);
    push_exp(e + 7, SEL_CODE, 8'h02);
    push_exp(e + 8, SEL_CHANGE, 8'h01);
    step(8);
    e = edge_cnt;
    mode = 2'd2;
    for (int c = e + 1; c <= e + 32; c++)
      push_exp(c, SEL_LED, phase_after(c - 1) ? 8'h04 : 8'h00);
    push_exp(e + 1, SEL_CHANGE, 8'h00);
    step(33);

    // One-cycle reset in the middle of debouncing 3'b111.
    e = edge_cnt;
    sw = 3'b111;
    mode = 2'd0;
    expect_span(e + 1, e + 4, SEL_LED, 8'h04);
    push_exp(e + 5, SEL_LED, 8'h00);
    push_exp(e + 5, SEL_CODE, 8'h00);
    push_exp(e + 5, SEL_CHANGE, 8'h00);
    expect_span(e + 6, e + 12, SEL_LED, 8'h01);
    expect_span(e + 6, e + 11, SEL_CODE, 8'h00);
    expect_span(e + 12, e + 14, SEL_CODE, 8'h07);
    expect_span(e + 6, e + 12, SEL_CHANGE, 8'h00);
    expect_span(e + 13, e + 14, SEL_LED, 8'h80);
    push_exp(e + 13, SEL_CHANGE, 8'h01);
    push_exp(e + 14, SEL_CHANGE, 8'h00);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(10);

    // Let the monitor consume the rest of the queue, with a bounded wait.
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check_eq("drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
